// File: rtl/udcnt_pkg.sv
// Shared types and next-count arithmetic for updown_counter_mod.
// Arithmetic is done at UDCNT_MAX_W+1 bits so any WIDTH up to UDCNT_MAX_W
// can reuse the same function without silent truncation.
package udcnt_pkg;

  typedef enum logic { DIR_DOWN = 1'b0, DIR_UP  = 1'b1 } dir_e;
  typedef enum logic { MODE_WRAP = 1'b0, MODE_SAT = 1'b1 } mode_e;

  localparam int unsigned UDCNT_MAX_W = 32;

  typedef logic [UDCNT_MAX_W-1:0] cnt_t;
  typedef logic [UDCNT_MAX_W:0]   ext_t;

  // Returns {wrapped, q_next}. q_next never exceeds max_val.
  function automatic ext_t next_count(input cnt_t  q,
                                      input cnt_t  step,
                                      input cnt_t  max_val,
                                      input dir_e  dir,
                                      input mode_e mode);
    ext_t q_x;
    ext_t s_x;
    ext_t mx_x;
    ext_t m_x;
    ext_t sum_x;
    ext_t res_x;
    logic wr;
    q_x   = {1'b0, q};
    s_x   = {1'b0, step};
    mx_x  = {1'b0, max_val};
    m_x   = mx_x + ext_t'(1);
    sum_x = q_x + s_x;
    res_x = q_x;
    wr    = 1'b0;
    if (step == '0) begin
      res_x = q_x;
    end else if (q > max_val) begin
      // Limit was lowered under the current count: snap to the far limit.
      wr    = 1'b1;
      res_x = (dir == DIR_UP) ? '0 : mx_x;
    end else if (dir == DIR_UP) begin
      if (sum_x <= mx_x) begin
        res_x = sum_x;
      end else begin
        wr    = 1'b1;
        res_x = (mode == MODE_SAT) ? mx_x : (sum_x - m_x);
      end
    end else begin
      if (s_x <= q_x) begin
        res_x = q_x - s_x;
      end else begin
        wr    = 1'b1;
        res_x = (mode == MODE_SAT) ? '0 : (q_x + m_x - s_x);
      end
    end
    return {wr, res_x[UDCNT_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/udcnt_prescale.sv
// Enable prescaler: tick is high on every PRESCALE-th cycle with en=1.
// The count holds while en=0 and returns to zero on clr.
module udcnt_prescale #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] pcnt_q;
  logic [CW-1:0] pcnt_d;
  logic          last;

  assign last = (pcnt_q == CW'(PRESCALE - 1));
  assign tick = en && last;

  // Next prescale count: clear wins, otherwise advance modulo PRESCALE on en.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = last ? '0 : (pcnt_q + CW'(1));
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, step and wrap/saturate mode.
// Optional feature macro: UDCNT_PRESCALE_EN qualifies en with a
// mod-PRESCALE prescaler; when undefined every en cycle is a count tick.
module updown_counter_mod
  import udcnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic              up_downb,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              wrapped
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic             ps_tick;
  logic             count_tick;
  ext_t             nc;
  dir_e             dir;
  mode_e            mode;

`ifdef UDCNT_PRESCALE_EN
  udcnt_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk   (clk),
    .reset (reset),
    .clr   (clr | load),
    .en    (en),
    .tick  (ps_tick)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign ps_tick = 1'b1;
`endif

  assign dir        = up_downb ? DIR_UP : DIR_DOWN;
  assign mode       = sat_mode ? MODE_SAT : MODE_WRAP;
  assign count_tick = en && !clr && !load && ps_tick;

  generate
    if (WIDTH < int'(UDCNT_MAX_W)) begin : g_unused_hi
      logic unused_nc_hi;
      assign unused_nc_hi = ^nc[UDCNT_MAX_W-1:WIDTH];
    end
  endgenerate

  // Next count and wrap flag: clr > load > count tick, otherwise hold.
  always_comb begin
    nc        = next_count(cnt_t'(count_q), cnt_t'(step), cnt_t'(max_val), dir, mode);
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (d > max_val) ? max_val : d;
    end else if (count_tick) begin
      count_d   = nc[WIDTH-1:0];
      wrapped_d = nc[UDCNT_MAX_W];
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign q       = count_q;
  assign wrapped = wrapped_q;
  assign tc      = (up_downb && (count_q == max_val)) || (!up_downb && (count_q == '0));

  a_step_legal: assert property (@(posedge clk) disable iff (reset)
    count_tick |-> (ext_t'(step) <= (ext_t'(max_val) + ext_t'(1))))
    else $error("step exceeds max_val+1");

endmodule
